// File: rtl/obstacle_gen.sv
// Obstacle generator and scroller: after a pseudo-random frame gap it spawns one
// obstacle in a pseudo-random lane and scrolls it down SPEED pixels per frame.
module obstacle_gen #(
  parameter int          HWIDTH       = 12,
  parameter int          VWIDTH       = 12,
  parameter int          LWIDTH       = 2,
  parameter int          NUM_LANES    = 3,
  parameter int          LANE_SPACING = 160,
  parameter int          SPAWN_V      = -40,
  parameter int          DESPAWN_V    = 480,
  parameter int          SPEED        = 4,
  parameter int          GAP_MIN      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     enable,
  output logic [LWIDTH-1:0]        obst_lane,
  output logic signed [VWIDTH-1:0] obst_voffset,
  output logic signed [HWIDTH-1:0] obst_hoffset,
  output logic                     obst_valid,
  output logic [15:0]              spawn_count
);

  localparam logic signed [VWIDTH-1:0] SPAWN_VOFF   = VWIDTH'(SPAWN_V);
  localparam logic signed [VWIDTH-1:0] DESPAWN_VOFF = VWIDTH'(DESPAWN_V);
  localparam logic signed [VWIDTH-1:0] SPEED_VOFF   = VWIDTH'(SPEED);
  localparam logic signed [HWIDTH-1:0] RESET_HOFF   = HWIDTH'(-LANE_SPACING);
  localparam logic [4:0]               GAP_MIN_W    = 5'(GAP_MIN);
  localparam logic [15:0]              LFSR_TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE
  } state_t;

  state_t                     state_q;
  logic [15:0]                lfsr_q;
  logic [15:0]                lfsr_d;
  logic [4:0]                 gap_q;
  logic [4:0]                 gap_load;
  logic [LWIDTH-1:0]          lane_q;
  logic [LWIDTH-1:0]          spawn_lane;
  logic signed [VWIDTH-1:0]   voff_q;
  logic signed [VWIDTH-1:0]   voff_next;
  logic signed [HWIDTH-1:0]   hoff_q;
  logic signed [HWIDTH-1:0]   spawn_hoff;
  logic                       valid_q;
  logic                       despawn;
  logic [15:0]                count_q;

  // Raw lane bits above the lane count fold back down (3 lanes: 3 -> 0).
  function automatic logic [LWIDTH-1:0] lane_of(input logic [1:0] raw);
    int r;
    r = int'(raw);
    if (r >= NUM_LANES) r = r - NUM_LANES;
    return LWIDTH'(r);
  endfunction

  function automatic logic signed [HWIDTH-1:0] hoff_of(input logic [LWIDTH-1:0] lane);
    return HWIDTH'((int'(lane) - 1) * LANE_SPACING);
  endfunction

  always_comb begin
    lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    gap_load   = GAP_MIN_W + {1'b0, lfsr_q[3:0]};
    spawn_lane = lane_of(lfsr_q[5:4]);
    spawn_hoff = hoff_of(spawn_lane);
    voff_next  = voff_q + SPEED_VOFF;
    despawn    = (voff_next >= DESPAWN_VOFF);
  end

  // The LFSR free-runs in every state so gap and lane depend on when play starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= 5'd0;
      lane_q  <= '0;
      voff_q  <= SPAWN_VOFF;
      hoff_q  <= RESET_HOFF;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else if (!enable) begin
      // Lane, hoffset and spawn count deliberately hold across a pause.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      voff_q  <= SPAWN_VOFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_WAIT;
          gap_q   <= gap_load;
        end
        S_WAIT: begin
          if (frame_tick) begin
            if (gap_q > 5'd1) begin
              gap_q <= gap_q - 5'd1;
            end else begin
              state_q <= S_ACTIVE;
              lane_q  <= spawn_lane;
              hoff_q  <= spawn_hoff;
              voff_q  <= SPAWN_VOFF;
              valid_q <= 1'b1;
              count_q <= count_q + 16'd1;
            end
          end
        end
        S_ACTIVE: begin
          if (frame_tick) begin
            if (despawn) begin
              state_q <= S_WAIT;
              gap_q   <= gap_load;
              valid_q <= 1'b0;
              voff_q  <= SPAWN_VOFF;
            end else begin
              voff_q <= voff_next;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          voff_q  <= SPAWN_VOFF;
        end
      endcase
    end
  end

  assign obst_lane    = lane_q;
  assign obst_voffset = voff_q;
  assign obst_hoffset = hoff_q;
  assign obst_valid   = valid_q;
  assign spawn_count  = count_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: a default instance plus one with DESPAWN_V = 481
// for the retire boundary; a reference LFSR picks the cycles that force gap/lane values.
module tb_obstacle_gen;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;

  logic [1:0]         a_lane, b_lane;
  logic signed [11:0] a_voff, b_voff;
  logic signed [11:0] a_hoff, b_hoff;
  logic               a_valid, b_valid;
  logic [15:0]        a_count, b_count;

  logic [15:0] m_lfsr;
  int n_vec = 0;
  int n_err = 0;

  obstacle_gen dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .obst_lane(a_lane), .obst_voffset(a_voff), .obst_hoffset(a_hoff),
    .obst_valid(a_valid), .spawn_count(a_count)
  );

  obstacle_gen #(.DESPAWN_V(481)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .obst_lane(b_lane), .obst_voffset(b_voff), .obst_hoffset(b_hoff),
    .obst_valid(b_valid), .spawn_count(b_count)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Called at a falling edge; one rising edge samples frame_tick = t.
  task automatic step(input logic t);
    frame_tick = t;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_gap_nibble(input logic [3:0] v);
    int n;
    n = 0;
    while (m_lfsr[3:0] != v && n < 200) begin
      step(1'b0);
      n++;
    end
    if (m_lfsr[3:0] != v) begin
      n_vec++; n_err++;
      $display("FAIL wait_gap_nibble: lfsr[3:0]=%0d never reached %0d", m_lfsr[3:0], v);
    end
  endtask

  task automatic wait_lane_bits(input logic [1:0] v);
    int n;
    n = 0;
    while (m_lfsr[5:4] != v && n < 200) begin
      step(1'b0);
      n++;
    end
    if (m_lfsr[5:4] != v) begin
      n_vec++; n_err++;
      $display("FAIL wait_lane_bits: lfsr[5:4]=%0d never reached %0d", m_lfsr[5:4], v);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_vec++; if (a_lane !== 2'd0) begin n_err++; $display("FAIL rst_lane: got %0d expected 0", a_lane); end
    n_vec++; if (a_voff !== -12'sd40) begin n_err++; $display("FAIL rst_voff: got %0d expected -40", a_voff); end
    n_vec++; if (a_hoff !== -12'sd160) begin n_err++; $display("FAIL rst_hoff: got %0d expected -160", a_hoff); end
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", a_valid); end
    n_vec++; if (a_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", a_count); end
    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step(1'b1);
    n_vec++; if (a_lane !== 2'd0) begin n_err++; $display("FAIL idle_lane: got %0d expected 0", a_lane); end
    n_vec++; if (a_voff !== -12'sd40) begin n_err++; $display("FAIL idle_voff: got %0d expected -40", a_voff); end
    n_vec++; if (a_hoff !== -12'sd160) begin n_err++; $display("FAIL idle_hoff: got %0d expected -160", a_hoff); end
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %0b expected 0", a_valid); end
    n_vec++; if (a_count !== 16'd0) begin n_err++; $display("FAIL idle_count: got %0d expected 0", a_count); end
  endtask

  // gap = 8 + 4 = 12: ticks 1..11 count down, tick 12 spawns in lane 1.
  task automatic test_spawn();
    wait_gap_nibble(4'd4);
    enable = 1'b1;
    step(1'b0);
    repeat (11) step(1'b1);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL spawn_early: got valid %0b expected 0 after 11 ticks", a_valid); end
    wait_lane_bits(2'd1);
    step(1'b1);
    n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL spawn_valid: got %0b expected 1", a_valid); end
    n_vec++; if (a_voff !== -12'sd40) begin n_err++; $display("FAIL spawn_voff: got %0d expected -40", a_voff); end
    n_vec++; if (a_count !== 16'd1) begin n_err++; $display("FAIL spawn_count: got %0d expected 1", a_count); end
    n_vec++; if (a_lane !== 2'd1) begin n_err++; $display("FAIL spawn_lane: got %0d expected 1", a_lane); end
    n_vec++; if (a_hoff !== 12'sd0) begin n_err++; $display("FAIL spawn_hoff: got %0d expected 0", a_hoff); end
  endtask

  task automatic test_scroll();
    repeat (10) step(1'b1);
    n_vec++; if (a_voff !== 12'sd0) begin n_err++; $display("FAIL scroll_voff: got %0d expected 0", a_voff); end
    n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL scroll_valid: got %0b expected 1", a_valid); end
    repeat (3) step(1'b0);
    n_vec++; if (a_voff !== 12'sd0) begin n_err++; $display("FAIL scroll_hold: got %0d expected 0", a_voff); end
  endtask

  task automatic test_despawn();
    int g;
    repeat (119) step(1'b1);
    n_vec++; if (a_voff !== 12'sd476) begin n_err++; $display("FAIL pre_despawn_a: got %0d expected 476", a_voff); end
    n_vec++; if (b_voff !== 12'sd476) begin n_err++; $display("FAIL pre_despawn_b: got %0d expected 476", b_voff); end
    g = 8 + int'(m_lfsr[3:0]);
    step(1'b1);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL despawn_valid: got %0b expected 0", a_valid); end
    n_vec++; if (a_voff !== -12'sd40) begin n_err++; $display("FAIL despawn_voff: got %0d expected -40", a_voff); end
    n_vec++; if (b_valid !== 1'b1) begin n_err++; $display("FAIL keep481_valid: got %0b expected 1", b_valid); end
    n_vec++; if (b_voff !== 12'sd480) begin n_err++; $display("FAIL keep481_voff: got %0d expected 480", b_voff); end
    repeat (g - 1) step(1'b1);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL regap_early: got valid %0b expected 0 after %0d ticks", a_valid, g - 1); end
    wait_lane_bits(2'd3);
    step(1'b1);
    n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL respawn_valid: got %0b expected 1", a_valid); end
    n_vec++; if (a_lane !== 2'd0) begin n_err++; $display("FAIL lane3_lane: got %0d expected 0", a_lane); end
    n_vec++; if (a_hoff !== -12'sd160) begin n_err++; $display("FAIL lane3_hoff: got %0d expected -160", a_hoff); end
    n_vec++; if (a_count !== 16'd2) begin n_err++; $display("FAIL respawn_count: got %0d expected 2", a_count); end
  endtask

  task automatic test_enable_drop();
    int g;
    repeat (2) step(1'b1);
    n_vec++; if (a_voff !== -12'sd32) begin n_err++; $display("FAIL drop_pre_voff: got %0d expected -32", a_voff); end
    enable = 1'b0;
    step(1'b1);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid: got %0b expected 0", a_valid); end
    n_vec++; if (a_voff !== -12'sd40) begin n_err++; $display("FAIL drop_voff: got %0d expected -40", a_voff); end
    n_vec++; if (a_count !== 16'd2) begin n_err++; $display("FAIL drop_count: got %0d expected 2", a_count); end
    n_vec++; if (a_lane !== 2'd0) begin n_err++; $display("FAIL drop_lane: got %0d expected 0", a_lane); end
    n_vec++; if (a_hoff !== -12'sd160) begin n_err++; $display("FAIL drop_hoff: got %0d expected -160", a_hoff); end
    repeat (5) step(1'b1);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL paused_valid: got %0b expected 0", a_valid); end
    g = 8 + int'(m_lfsr[3:0]);
    enable = 1'b1;
    step(1'b0);
    repeat (g - 1) step(1'b1);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reen_early: got valid %0b expected 0 after %0d ticks", a_valid, g - 1); end
    wait_lane_bits(2'd2);
    step(1'b1);
    n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL reen_valid: got %0b expected 1", a_valid); end
    n_vec++; if (a_lane !== 2'd2) begin n_err++; $display("FAIL lane2_lane: got %0d expected 2", a_lane); end
    n_vec++; if (a_hoff !== 12'sd160) begin n_err++; $display("FAIL lane2_hoff: got %0d expected 160", a_hoff); end
    n_vec++; if (a_count !== 16'd3) begin n_err++; $display("FAIL reen_count: got %0d expected 3", a_count); end
  endtask

  task automatic test_async_reset();
    repeat (3) step(1'b1);
    n_vec++; if (a_voff !== -12'sd28) begin n_err++; $display("FAIL pre_arst_voff: got %0d expected -28", a_voff); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (a_lane !== 2'd0) begin n_err++; $display("FAIL arst_lane: got %0d expected 0", a_lane); end
    n_vec++; if (a_voff !== -12'sd40) begin n_err++; $display("FAIL arst_voff: got %0d expected -40", a_voff); end
    n_vec++; if (a_hoff !== -12'sd160) begin n_err++; $display("FAIL arst_hoff: got %0d expected -160", a_hoff); end
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %0b expected 0", a_valid); end
    n_vec++; if (a_count !== 16'd0) begin n_err++; $display("FAIL arst_count: got %0d expected 0", a_count); end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_scroll();
    test_despawn();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
